// File: rtl/spi_sram_pkg.sv
// spi_sram_pkg: command codes and FSM states shared by the SPI SRAM target and its controller
package spi_sram_pkg;

    typedef enum logic [2:0] {CMD, ADDR, READ, WRITE, RDMR, IGNORE} state_t;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_RDMR  = 8'h05;

endpackage

// File: rtl/spi_sram_mem.sv
// spi_sram_mem: byte-wide storage with a synchronous write port and a combinational read port
module spi_sram_mem
    import spi_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] adr,
    input  logic [7:0]            wdat,
    output logic [7:0]            rdat
);

    logic [7:0] mem [2**ADDR_WIDTH];

    // contents are deliberately never reset, like a real SRAM
    always_ff @(posedge clk_i)
        if (we) mem[adr] <= wdat;

    assign rdat = mem[adr];

endmodule

// File: rtl/spi_sram_target.sv
// spi_sram_target: SPI mode-0 responder emulating a sequential-mode serial SRAM
module spi_sram_target
    import spi_sram_pkg::*;
#(
    parameter int         ADDR_WIDTH = 8,
    parameter logic [7:0] MODE_VALUE = 8'h40
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sck,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  busy_o,
    output logic                  wr_stb_o,
    output logic [ADDR_WIDTH-1:0] wr_adr_o,
    output logic [7:0]            wr_dat_o
);

    state_t                  state;
    logic                    sck_q;
    logic                    rise;
    logic                    fall;
    logic                    byte_done;
    logic                    mem_we;
    logic                    rd;
    logic                    tx_state;
    logic [2:0]              bit_cnt;
    logic [1:0]              adr_cnt;
    logic [6:0]              shreg;
    logic [7:0]              new_byte;
    logic [7:0]              out_sr;
    logic [7:0]              rdat;
    logic [7:0]              load_byte;
    logic [ADDR_WIDTH-1:0]   ptr;

    assign rise      = sck & ~sck_q & ~cs_n;
    assign fall      = ~sck & sck_q & ~cs_n;
    assign new_byte  = {shreg, mosi};
    assign byte_done = rise && bit_cnt == 3'd7;
    assign mem_we    = byte_done && state == WRITE;
    assign tx_state  = state == READ || state == RDMR;
    assign load_byte = state == READ ? rdat : MODE_VALUE;

    spi_sram_mem #(.ADDR_WIDTH(ADDR_WIDTH)) u_mem (
        .clk_i (clk_i),
        .we    (mem_we),
        .adr   (ptr),
        .wdat  (new_byte),
        .rdat  (rdat)
    );

    // sck history for edge detection and registered select indication
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            sck_q  <= 1'b0;
            busy_o <= 1'b0;
        end else begin
            sck_q  <= sck;
            busy_o <= ~cs_n;
        end

    // bit shifting, command/address decode, write commit and miso generation
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            state    <= CMD;
            bit_cnt  <= 3'd0;
            adr_cnt  <= 2'd0;
            shreg    <= 7'd0;
            out_sr   <= 8'd0;
            rd       <= 1'b0;
            ptr      <= '0;
            miso     <= 1'b0;
            wr_stb_o <= 1'b0;
            wr_adr_o <= '0;
            wr_dat_o <= 8'd0;
        end else begin
            wr_stb_o <= 1'b0;
            if (cs_n) begin
                state   <= CMD;
                bit_cnt <= 3'd0;
                miso    <= 1'b0;
            end else begin
                if (rise) begin
                    shreg   <= {shreg[5:0], mosi};
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (byte_done)
                    case (state)
                        CMD: begin
                            state   <= (new_byte == CMD_READ || new_byte == CMD_WRITE) ? ADDR :
                                       new_byte == CMD_RDMR ? RDMR : IGNORE;
                            rd      <= new_byte == CMD_READ;
                            adr_cnt <= 2'd0;
                        end
                        ADDR: begin
                            // shifting whole bytes through ptr keeps only the implemented low bits
                            ptr     <= ADDR_WIDTH'({ptr, new_byte});
                            adr_cnt <= adr_cnt + 2'd1;
                            if (adr_cnt == 2'd2) state <= rd ? READ : WRITE;
                        end
                        WRITE: begin
                            wr_stb_o <= 1'b1;
                            wr_adr_o <= ptr;
                            wr_dat_o <= new_byte;
                            ptr      <= ptr + 1'b1;
                        end
                        default: ;
                    endcase
                // a fall with bit_cnt at 0 is the first fall after a byte boundary
                if (fall) begin
                    if (tx_state && bit_cnt == 3'd0) begin
                        miso   <= load_byte[7];
                        out_sr <= {load_byte[6:0], 1'b0};
                        if (state == READ) ptr <= ptr + 1'b1;
                    end else if (tx_state) begin
                        miso   <= out_sr[7];
                        out_sr <= {out_sr[6:0], 1'b0};
                    end else
                        miso <= 1'b0;
                end
            end
        end

endmodule

// File: tb/tb_spi_sram_target.sv
// tb_spi_sram_target: directed SPI transactions against the serial SRAM target
module tb_spi_sram_target;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       sck   = 1'b0;
    logic       cs_n  = 1'b1;
    logic       mosi  = 1'b0;
    logic       miso;
    logic       busy_o;
    logic       wr_stb_o;
    logic [7:0] wr_adr_o;
    logic [7:0] wr_dat_o;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [15:0] stbq[$];
    logic [7:0] rx;

    spi_sram_target dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .sck      (sck),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .miso     (miso),
        .busy_o   (busy_o),
        .wr_stb_o (wr_stb_o),
        .wr_adr_o (wr_adr_o),
        .wr_dat_o (wr_dat_o)
    );

    always #5 clk_i = ~clk_i;

    // record every write strobe with its address and data
    always @(negedge clk_i)
        if (wr_stb_o) stbq.push_back({wr_adr_o, wr_dat_o});

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cs_start();
        @(negedge clk_i);
        sck  = 1'b0;
        cs_n = 1'b0;
    endtask

    task automatic cs_stop();
        @(negedge clk_i);
        sck = 1'b0;
        @(negedge clk_i);
        cs_n = 1'b1;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic xfer(input logic [7:0] tx, input int n, output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            @(negedge clk_i);
            sck  = 1'b0;
            mosi = tx[i];
            @(negedge clk_i);
            r[i] = miso;
            sck  = 1'b1;
        end
    endtask

    task automatic hdr(input logic [7:0] cmd, input logic [23:0] adr);
        logic [7:0] d;
        xfer(cmd, 8, d);
        xfer(adr[23:16], 8, d);
        xfer(adr[15:8], 8, d);
        xfer(adr[7:0], 8, d);
    endtask

    task automatic write1(input logic [23:0] adr, input logic [7:0] dat);
        logic [7:0] d;
        cs_start();
        hdr(8'h02, adr);
        xfer(dat, 8, d);
        cs_stop();
    endtask

    task automatic read1(input logic [23:0] adr, output logic [7:0] dat);
        cs_start();
        hdr(8'h03, adr);
        xfer(8'h00, 8, dat);
        cs_stop();
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        check("rst_miso", miso, 0);
        check("rst_busy", busy_o, 0);
        check("rst_stb", wr_stb_o, 0);
        check("rst_adr", wr_adr_o, 0);
        check("rst_dat", wr_dat_o, 0);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        // single write then read back
        cs_start();
        repeat (2) @(negedge clk_i);
        check("busy_sel", busy_o, 1);
        hdr(8'h02, 24'h000010);
        xfer(8'h5A, 8, rx);
        cs_stop();
        check("busy_idle", busy_o, 0);
        check("w1_nstb", stbq.size(), 1);
        if (stbq.size() > 0) check("w1_stb", stbq[0], 16'h105A);
        stbq.delete();
        read1(24'h000010, rx);
        check("r1_dat", rx, 8'h5A);

        // burst write wrapping past the top of the array
        cs_start();
        hdr(8'h02, 24'h0000FE);
        xfer(8'h11, 8, rx);
        xfer(8'h22, 8, rx);
        xfer(8'h33, 8, rx);
        cs_stop();
        check("bw_nstb", stbq.size(), 3);
        if (stbq.size() == 3) begin
            check("bw_stb0", stbq[0], 16'hFE11);
            check("bw_stb1", stbq[1], 16'hFF22);
            check("bw_stb2", stbq[2], 16'h0033);
        end
        stbq.delete();
        cs_start();
        hdr(8'h03, 24'h0000FE);
        xfer(8'h00, 8, rx);
        check("br_0", rx, 8'h11);
        xfer(8'h00, 8, rx);
        check("br_1", rx, 8'h22);
        xfer(8'h00, 8, rx);
        check("br_2", rx, 8'h33);
        cs_stop();

        // mode register read repeats the mode byte
        cs_start();
        xfer(8'h05, 8, rx);
        xfer(8'hFF, 8, rx);
        check("rdmr_0", rx, 8'h40);
        xfer(8'hA5, 8, rx);
        check("rdmr_1", rx, 8'h40);
        cs_stop();
        check("rdmr_nstb", stbq.size(), 0);
        read1(24'h000010, rx);
        check("rdmr_mem", rx, 8'h5A);

        // unknown command is ignored until deselect
        cs_start();
        xfer(8'h9F, 8, rx);
        for (int i = 0; i < 4; i++) begin
            xfer(8'hFF, 8, rx);
            check($sformatf("ign_%0d", i), rx, 8'h00);
        end
        cs_stop();
        check("ign_nstb", stbq.size(), 0);
        read1(24'h000010, rx);
        check("ign_next", rx, 8'h5A);

        // aborted write byte leaves memory untouched
        write1(24'h000020, 8'h77);
        stbq.delete();
        cs_start();
        hdr(8'h02, 24'h000020);
        xfer(8'hA5, 5, rx);
        cs_stop();
        check("abort_nstb", stbq.size(), 0);
        read1(24'h000020, rx);
        check("abort_mem", rx, 8'h77);

        // asynchronous reset in the middle of a read
        cs_start();
        hdr(8'h03, 24'h0000FE);
        xfer(8'h00, 4, rx);
        check("mid_bits", rx, 8'h10);
        check("mid_miso", miso, 1);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("arst_miso", miso, 0);
        check("arst_busy", busy_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        cs_n  = 1'b1;
        sck   = 1'b0;
        repeat (2) @(negedge clk_i);
        read1(24'h0000FE, rx);
        check("arst_read", rx, 8'h11);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
